// File: rtl/riscv_csr_ctrl_pkg.sv
// Purpose : shared types and constants for the machine-mode CSR controller.
// Contents: CSR function encoding, CSR address map, mstatus bit positions,
//           controller FSM state type.
package riscv_csr_ctrl_pkg;

  // Low two bits of funct3 for CSRRW/CSRRS/CSRRC (and their immediate forms).
  typedef enum logic [1:0] {
    CSR_W = 2'b01,
    CSR_S = 2'b10,
    CSR_C = 2'b11
  } csr_fun_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic {
    CSR_IDLE,
    CSR_EXEC
  } csr_ctrl_state_t;

endpackage

// File: rtl/riscv_csr_alu.sv
// Purpose : computes the new CSR value for CSRRW / CSRRS / CSRRC.
// Ports   : reg_data (rs1 or zimm), csr_data (current CSR value),
//           csr_fun (operation) -> new_data (value to write back). Purely combinational.
module riscv_csr_alu
  import riscv_csr_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic [WORD_LENGTH-1:0] reg_data,
  input  logic [WORD_LENGTH-1:0] csr_data,
  input  csr_fun_t               csr_fun,
  output logic [WORD_LENGTH-1:0] new_data
);

  always_comb begin
    new_data = csr_data;
    case (csr_fun)
      CSR_W:   new_data = reg_data;
      CSR_S:   new_data = csr_data | reg_data;
      CSR_C:   new_data = csr_data & ~reg_data;
      default: new_data = csr_data;
    endcase
  end

endmodule

// File: rtl/riscv_csr_ctrl.sv
// Purpose : machine-mode CSR file + 64-bit cycle counter; sequences pipeline
//           CSR read-modify-write and applies trap-entry / mret updates.
// Ports   : clk, rst_n (sync, active-low); req_* / resp_* pipeline CSR port
//           (accept -> response one cycle later); trap_* and mret_valid
//           side-band updates; trap_vector / mepc_out / mie_out register taps.
module riscv_csr_ctrl
  import riscv_csr_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [11:0]            req_addr,
  input  csr_fun_t               req_fun,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic                   req_nowrite,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  input  logic                   trap_valid,
  input  logic [WORD_LENGTH-1:0] trap_cause,
  input  logic [WORD_LENGTH-1:0] trap_pc,
  input  logic                   mret_valid,
  output logic [WORD_LENGTH-1:0] trap_vector,
  output logic [WORD_LENGTH-1:0] mepc_out,
  output logic                   mie_out
);

  csr_ctrl_state_t state_q, state_d;

  // Request latched at accept, consumed in EXEC.
  logic [11:0]            addr_q;
  csr_fun_t               fun_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic                   nowrite_q;

  // Architectural state. mstatus is kept as its two live bits only.
  logic                   mie_q;
  logic                   mpie_q;
  logic [WORD_LENGTH-1:0] mtvec_q;
  logic [WORD_LENGTH-1:0] mscratch_q;
  logic [WORD_LENGTH-1:0] mepc_q;
  logic [WORD_LENGTH-1:0] mcause_q;
  logic [63:0]            cycle_q;

  logic [WORD_LENGTH-1:0] csr_rdata;
  logic [WORD_LENGTH-1:0] csr_new;
  logic                   addr_hit;
  logic                   addr_ro;
  logic                   legal;
  logic                   side_evt;
  logic                   csr_we;

  // Trap/mret own the CSR file for the cycle; they block accepts and kill EXEC.
  assign side_evt = trap_valid | mret_valid;

  // Read mux on the latched address.
  always_comb begin
    csr_rdata = '0;
    addr_hit  = 1'b1;
    addr_ro   = 1'b0;
    case (addr_q)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mie_q;
        csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_CYCLE: begin
        csr_rdata = cycle_q[WORD_LENGTH-1:0];
        addr_ro   = 1'b1;
      end
      CSR_CYCLEH: begin
        csr_rdata = WORD_LENGTH'(cycle_q[63:32]);
        addr_ro   = 1'b1;
      end
      default:      addr_hit = 1'b0;
    endcase
  end

  // Counter reads are fine; only an actual write to them is illegal.
  assign legal = addr_hit & ~(addr_ro & ~nowrite_q);

  riscv_csr_alu #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_alu (
    .reg_data (wdata_q),
    .csr_data (csr_rdata),
    .csr_fun  (fun_q),
    .new_data (csr_new)
  );

  assign csr_we = (state_q == CSR_EXEC) & ~side_evt & legal & ~nowrite_q;

  // FSM next state and response outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state_q)
      CSR_IDLE: begin
        req_ready = rst_n & ~side_evt;
        if (req_valid && req_ready) state_d = CSR_EXEC;
      end
      CSR_EXEC: begin
        state_d = CSR_IDLE;
        // A reset or side-band update in this cycle drops the response.
        if (rst_n && !side_evt) begin
          resp_valid = 1'b1;
          resp_err   = ~legal;
          resp_rdata = legal ? csr_rdata : '0;
        end
      end
      default: state_d = CSR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CSR_IDLE;
      addr_q    <= '0;
      fun_q     <= CSR_W;
      wdata_q   <= '0;
      nowrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) begin
        addr_q    <= req_addr;
        fun_q     <= req_fun;
        wdata_q   <= req_wdata;
        nowrite_q <= req_nowrite;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      cycle_q    <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (trap_valid) begin
        mepc_q   <= {trap_pc[WORD_LENGTH-1:2], 2'b00};
        mcause_q <= trap_cause;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_valid) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (addr_q)
          CSR_MSTATUS: begin
            mie_q  <= csr_new[MSTATUS_MIE_BIT];
            mpie_q <= csr_new[MSTATUS_MPIE_BIT];
          end
          CSR_MTVEC:    mtvec_q    <= {csr_new[WORD_LENGTH-1:2], 2'b00};
          CSR_MSCRATCH: mscratch_q <= csr_new;
          CSR_MEPC:     mepc_q     <= {csr_new[WORD_LENGTH-1:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= csr_new;
          default: ;
        endcase
      end
    end
  end

  assign trap_vector = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mie_out     = mie_q;

endmodule
